// File: rtl/display_fb_if.sv
// rtl/display_fb_if.sv - OLED fetch, CPU access and clear-screen signal bundle for display_fb
interface display_fb_if;
   logic       read;
   logic [5:0] row_idx;
   logic [6:0] column_idx;
   logic [7:0] data;
   logic       ack;
   logic       cpu_req;
   logic [1:0] cpu_op;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic [7:0] cpu_rdata;
   logic       cpu_collision;
   logic       cpu_ack;
   logic       cls;
   logic       busy;

   modport master (
      output read, row_idx, column_idx, cpu_req, cpu_op, cpu_addr, cpu_wdata, cls,
      input  data, ack, cpu_rdata, cpu_collision, cpu_ack, busy
   );

   modport slave (
      input  read, row_idx, column_idx, cpu_req, cpu_op, cpu_addr, cpu_wdata, cls,
      output data, ack, cpu_rdata, cpu_collision, cpu_ack, busy
   );
endinterface

// File: rtl/display_fb.sv
// rtl/display_fb.sv - CHIP-8 64x32 framebuffer with CPU read/write/XOR port and 2x-scaled OLED column fetch
module display_fb (
   input  logic         clk,
   input  logic         rst_n,
   display_fb_if.slave  bus
);
   typedef enum logic [1:0] {F_IDLE, F_ISSUE, F_CAPTURE, F_ACK} f_state_t;
   typedef enum logic [1:0] {C_IDLE, C_RD, C_WR, C_ACK} c_state_t;

   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_XOR   = 2'b10;

   logic [7:0] mem [256];
   logic [7:0] ram_q;
   logic       ram_we;
   logic       ram_re;
   logic [7:0] ram_addr;
   logic [7:0] ram_wd;

   logic       busy_q;
   logic [7:0] clr_addr;
   logic       clr_gnt;

   c_state_t   c_state, c_next;
   logic [1:0] c_op;
   logic [7:0] c_addr;
   logic [7:0] c_wdata;
   logic [7:0] cpu_rdata_q;
   logic       cpu_coll_q;
   logic       cpu_ack_q;
   logic       cpu_gnt;

   f_state_t   f_state, f_next;
   logic [2:0] f_page;
   logic [5:0] f_col;
   logic [1:0] f_k;
   logic [2:0] f_bits;
   logic       f_rd_d;
   logic       f_gnt;
   logic [7:0] data_q;
   logic [2:0] bit_sel;
   logic       pix;

   logic       unused_bits;
   assign unused_bits = ^{bus.row_idx[5:3], bus.column_idx[0]};

   // Leftmost CHIP-8 pixel is the byte MSB.
   assign bit_sel = 3'd7 - f_col[2:0];
   assign pix     = ram_q[bit_sel];

   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wd;
      if (ram_re) ram_q <= mem[ram_addr];
   end

   // Clear beats CPU except in the write half of an XOR, which must stay atomic.
   always_comb begin
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      ram_addr = '0;
      ram_wd   = '0;
      clr_gnt  = 1'b0;
      cpu_gnt  = 1'b0;
      f_gnt    = 1'b0;
      if (busy_q && c_state != C_WR) begin
         clr_gnt  = 1'b1;
         ram_we   = 1'b1;
         ram_addr = clr_addr;
      end else if (c_state == C_RD) begin
         cpu_gnt  = 1'b1;
         ram_addr = c_addr;
         if (c_op == OP_WRITE) begin
            ram_we = 1'b1;
            ram_wd = c_wdata;
         end else begin
            ram_re = 1'b1;
         end
      end else if (c_state == C_WR) begin
         ram_we   = 1'b1;
         ram_addr = c_addr;
         ram_wd   = ram_q ^ c_wdata;
      end else if (f_state == F_ISSUE) begin
         f_gnt    = 1'b1;
         ram_re   = 1'b1;
         ram_addr = {f_page, f_k, f_col[5:3]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         clr_addr <= '0;
      end else if (!busy_q) begin
         if (bus.cls) begin
            busy_q   <= 1'b1;
            clr_addr <= '0;
         end
      end else if (clr_gnt) begin
         if (clr_addr == 8'hFF) busy_q <= 1'b0;
         clr_addr <= clr_addr + 8'd1;
      end
   end

   always_comb begin
      c_next = c_state;
      case (c_state)
         C_IDLE: if (bus.cpu_req) c_next = C_RD;
         C_RD:   if (cpu_gnt) c_next = (c_op == OP_XOR) ? C_WR : C_ACK;
         C_WR:   c_next = C_ACK;
         C_ACK:  c_next = C_IDLE;
         default: c_next = C_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_state     <= C_IDLE;
         c_op        <= '0;
         c_addr      <= '0;
         c_wdata     <= '0;
         cpu_rdata_q <= '0;
         cpu_coll_q  <= 1'b0;
         cpu_ack_q   <= 1'b0;
      end else begin
         c_state   <= c_next;
         cpu_ack_q <= 1'b0;
         if (c_state == C_IDLE && bus.cpu_req) begin
            c_op    <= bus.cpu_op;
            c_addr  <= bus.cpu_addr;
            c_wdata <= bus.cpu_wdata;
         end
         // ram_q still holds the byte fetched in RD: no read is issued in RD->ACK or WR.
         if (c_state == C_ACK) begin
            cpu_ack_q   <= 1'b1;
            cpu_rdata_q <= (c_op == OP_WRITE) ? c_wdata : ram_q;
            cpu_coll_q  <= (c_op == OP_XOR) && (|(ram_q & c_wdata));
         end
      end
   end

   always_comb begin
      f_next = f_state;
      case (f_state)
         F_IDLE:    if (bus.read) f_next = F_ISSUE;
         F_ISSUE:   if (f_gnt && f_k == 2'd3) f_next = F_CAPTURE;
         F_CAPTURE: f_next = F_ACK;
         F_ACK:     f_next = F_IDLE;
         default:   f_next = F_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_state <= F_IDLE;
         f_page  <= '0;
         f_col   <= '0;
         f_k     <= '0;
         f_bits  <= '0;
         f_rd_d  <= 1'b0;
         data_q  <= '0;
      end else begin
         f_state <= f_next;
         f_rd_d  <= f_gnt;
         if (f_state == F_IDLE && bus.read) begin
            f_page <= bus.row_idx[2:0];
            f_col  <= bus.column_idx[6:1];
            f_k    <= '0;
         end
         if (f_gnt) f_k <= f_k + 2'd1;
         // Rows arrive top first; after three shifts f_bits = {b2, b1, b0}.
         if (f_rd_d) f_bits <= {pix, f_bits[2:1]};
         if (f_state == F_CAPTURE) begin
            data_q <= {pix, pix, f_bits[2], f_bits[2], f_bits[1], f_bits[1], f_bits[0], f_bits[0]};
         end
      end
   end

   assign bus.data          = data_q;
   assign bus.ack           = (f_state == F_ACK);
   assign bus.cpu_rdata     = cpu_rdata_q;
   assign bus.cpu_collision = cpu_coll_q;
   assign bus.cpu_ack       = cpu_ack_q;
   assign bus.busy          = busy_q;
endmodule

// File: tb/tb_display_fb.sv
// tb/tb_display_fb.sv - scoreboard bench for display_fb against a byte-array framebuffer model
module tb_display_fb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   display_fb_if bus();
   display_fb u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic       chk_rd;
      logic [7:0] rdata;
      logic       coll;
   } cpu_exp_t;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] fb [256];
   cpu_exp_t   cq[$];
   logic [7:0] fq[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] fetch_exp(input logic [2:0] p, input logic [5:0] c);
      logic [7:0] r;
      logic [7:0] byte_v;
      logic [4:0] row;
      logic [2:0] bsel;
      r = '0;
      bsel = 3'd7 - c[2:0];
      for (int k = 0; k < 4; k++) begin
         row = {p, 2'(k)};
         byte_v = fb[{row, c[5:3]}];
         r[2*k]   = byte_v[bsel];
         r[2*k+1] = byte_v[bsel];
      end
      return r;
   endfunction

   function automatic cpu_exp_t model_cpu(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wd);
      cpu_exp_t e;
      e.chk_rd = (op != 2'b01);
      e.rdata  = fb[addr];
      e.coll   = (op == 2'b10) ? |(fb[addr] & wd) : 1'b0;
      if (op == 2'b01) fb[addr] = wd;
      else if (op == 2'b10) fb[addr] = fb[addr] ^ wd;
      return e;
   endfunction

   always @(negedge clk) begin : monitor
      cpu_exp_t ce;
      logic [7:0] fe;
      if (rst_n) begin
         if (bus.ack) begin
            if (fq.size() == 0) check_eq("stray_ack", {31'd0, bus.ack}, 32'd0);
            else begin
               fe = fq.pop_front();
               check_eq("fetch_data", bus.data, fe);
            end
         end
         if (bus.cpu_ack) begin
            if (cq.size() == 0) check_eq("stray_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
            else begin
               ce = cq.pop_front();
               if (ce.chk_rd) check_eq("cpu_rdata", bus.cpu_rdata, ce.rdata);
               check_eq("cpu_collision", bus.cpu_collision, ce.coll);
            end
         end
      end
   end

   task automatic cpu_access(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wd, input int lat);
      int n;
      cq.push_back(model_cpu(op, addr, wd));
      bus.cpu_req = 1'b1; bus.cpu_op = op; bus.cpu_addr = addr; bus.cpu_wdata = wd;
      tick();
      bus.cpu_req = 1'b0;
      n = 1;
      while (!bus.cpu_ack && n < 600) begin tick(); n++; end
      check_eq("cpu_ack_seen", bus.cpu_ack, 1);
      if (lat > 0) check_eq("cpu_latency", n, lat);
      tick();
   endtask

   task automatic fetch(input logic [5:0] row, input logic [6:0] col, input int lat);
      int n;
      fq.push_back(fetch_exp(row[2:0], col[6:1]));
      bus.read = 1'b1; bus.row_idx = row; bus.column_idx = col;
      tick();
      bus.read = 1'b0;
      n = 1;
      while (!bus.ack && n < 600) begin tick(); n++; end
      check_eq("ack_seen", bus.ack, 1);
      if (lat > 0) check_eq("fetch_latency", n, lat);
      tick();
   endtask

   task automatic clear_screen();
      int n;
      bus.cls = 1'b1;
      tick();
      bus.cls = 1'b0;
      check_eq("busy_rise", bus.busy, 1);
      n = 0;
      while (bus.busy && n < 400) begin n++; tick(); end
      check_eq("busy_cycles", n, 256);
      for (int a = 0; a < 256; a++) fb[a] = 8'h00;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_data"}, bus.data, 0);
      check_eq({tag, "_ack"}, bus.ack, 0);
      check_eq({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
      check_eq({tag, "_cpu_collision"}, bus.cpu_collision, 0);
      check_eq({tag, "_cpu_ack"}, bus.cpu_ack, 0);
      check_eq({tag, "_busy"}, bus.busy, 0);
   endtask

   initial begin
      int n, cpu_at, f_at;
      bus.read = 1'b0; bus.row_idx = '0; bus.column_idx = '0;
      bus.cpu_req = 1'b0; bus.cpu_op = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.cls = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      clear_screen();
      fetch(6'd3, 7'd77, 6);

      cpu_access(2'b01, 8'h00, 8'h80, 3);
      fetch(6'd0, 7'd0, 6);
      fetch(6'd0, 7'd1, 6);
      fetch(6'd0, 7'd2, 6);

      cpu_access(2'b01, 8'h00, 8'h00, 3);
      cpu_access(2'b01, 8'h18, 8'hFF, 3);
      cpu_access(2'b01, 8'hF8, 8'hFF, 3);
      fetch(6'd0, 7'd0, 6);
      fetch(6'b111_111, 7'd0, 6);
      fetch(6'd7, 7'd127, 6);

      cpu_access(2'b01, 8'h42, 8'h3C, 3);
      cpu_access(2'b10, 8'h42, 8'h0F, 4);
      cpu_access(2'b00, 8'h42, 8'h00, 3);
      cpu_access(2'b10, 8'h43, 8'h40, 4);
      cpu_access(2'b11, 8'h43, 8'h00, 3);

      // XOR-write and fetch of the same byte launched together
      cq.push_back(model_cpu(2'b10, 8'h42, 8'h80));
      fq.push_back(fetch_exp(3'd2, 6'd16));
      bus.cpu_req = 1'b1; bus.cpu_op = 2'b10; bus.cpu_addr = 8'h42; bus.cpu_wdata = 8'h80;
      bus.read = 1'b1; bus.row_idx = 6'd2; bus.column_idx = 7'd32;
      tick();
      bus.cpu_req = 1'b0; bus.read = 1'b0;
      cpu_at = 0; f_at = 0; n = 1;
      while ((cpu_at == 0 || f_at == 0) && n < 40) begin
         if (bus.cpu_ack && cpu_at == 0) cpu_at = n;
         if (bus.ack && f_at == 0) f_at = n;
         tick(); n++;
      end
      check_eq("contend_cpu_latency", cpu_at, 4);
      check_eq("contend_fetch_latency", f_at, 8);

      // Clear and write launched together: write lands after the clear
      for (int a = 0; a < 256; a++) fb[a] = 8'h00;
      cq.push_back(model_cpu(2'b01, 8'h10, 8'h5A));
      bus.cls = 1'b1;
      bus.cpu_req = 1'b1; bus.cpu_op = 2'b01; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'h5A;
      tick();
      bus.cls = 1'b0; bus.cpu_req = 1'b0;
      n = 1;
      while (!bus.cpu_ack && n < 600) begin tick(); n++; end
      check_eq("cls_cpu_latency", n, 259);
      tick();
      cpu_access(2'b00, 8'h10, 8'h00, 3);
      cpu_access(2'b00, 8'h42, 8'h00, 3);
      fetch(6'd0, 7'd3, 6);

      // Reset in the middle of a fetch
      bus.read = 1'b1; bus.row_idx = 6'd0; bus.column_idx = 7'd3;
      tick();
      bus.read = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_fetch");
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (30) tick();

      // Reset in the middle of a clear with a CPU write pending
      bus.cls = 1'b1;
      bus.cpu_req = 1'b1; bus.cpu_op = 2'b01; bus.cpu_addr = 8'h20; bus.cpu_wdata = 8'hAA;
      tick();
      bus.cls = 1'b0; bus.cpu_req = 1'b0;
      repeat (20) tick();
      check_eq("mid_clear_busy", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_clear");
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (30) tick();

      clear_screen();
      fetch(6'd3, 7'd77, 6);
      cpu_access(2'b00, 8'h10, 8'h00, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/display_fb.md
# display_fb

CHIP-8 display framebuffer: 64×32 monochrome pixels held in a 256-byte synchronous RAM. It sits between the CPU, which reads, writes and XOR-draws framebuffer bytes, and the OLED driver, which it feeds through the driver's read/ack pixel-column interface. The CHIP-8 image is scaled 2× in both axes to fill the 128×64 panel. This block replaces the test-pattern source on the OLED side.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `read` in 1: OLED fetch request, single-cycle pulse.
- `row_idx` in 6: OLED page index; only bits [2:0] are used (pages 0–7), bits [5:3] are ignored.
- `column_idx` in 7: OLED column, 0–127.
- `data` out 8: vertical pixel byte; bit0 is the top row of the page, 1 means pixel lit.
- `ack` out 1: one-cycle pulse; `data` is valid from this cycle until the next `ack`.
- `cpu_req` in 1: CPU access request, single-cycle pulse.
- `cpu_op` in 2: operation code, sampled with `cpu_req`.
  - 00: read.
  - 01: write.
  - 10: XOR-write.
  - 11: reserved, treated as read.
- `cpu_addr` in 8: byte address, `{row[4:0], col[5:3]}`; MSB of each byte is the leftmost pixel.
- `cpu_wdata` in 8: write or XOR data.
- `cpu_rdata` out 8: read data (for XOR-write: the old byte), valid at `cpu_ack`.
- `cpu_collision` out 1: for XOR-write, `|(old & wdata)`; 0 for the other ops. Valid at `cpu_ack`.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cls` in 1: clear-screen pulse.
- `busy` out 1: high while a clear is in progress.

## Operation
- RAM: 256×8, single port, synchronous read with one-cycle latency. Contents are not reset.
- Port arbitration, one RAM access per cycle, fixed priority: clear > CPU > OLED fetch.
- `cls`:
  - `busy` rises the next cycle.
  - Zeros are written to addresses 0..255, one per cycle.
  - `busy` falls the cycle after address 255 is written.
  - `cls` is ignored while `busy` is high.
- CPU access:
  - `cpu_req` latches op, address and data into a pending slot.
  - A `cpu_req` arriving while the slot is occupied is dropped; this is illegal usage.
  - Read: one RAM read cycle.
  - Write: one RAM write cycle.
  - XOR-write: a read cycle, then a write cycle storing `old ^ wdata`. The two cycles are atomic; nothing may interleave between them.
- OLED fetch:
  - `read` latches the page `p = row_idx[2:0]` and the CHIP-8 column `c = column_idx[6:1]`.
  - The FSM reads CHIP-8 rows `r = 4p+k` for k = 0..3 at address `{r, c[5:3]}` and extracts bit `7 - c[2:0]` as `b_k`.
  - Result: `data = {b3,b3,b2,b2,b1,b1,b0,b0}`. Each CHIP-8 pixel fills 2 OLED rows; columns 2c and 2c+1 give identical bytes.
  - A `read` arriving while a fetch is pending is dropped.
- Fetch FSM states:
  - IDLE → ISSUE on latch.
  - ISSUE(k): advances k only when granted the RAM.
  - CAPTURE: collects the last byte.
  - ACK → IDLE.
- CPU FSM states:
  - IDLE → RD on latch.
  - RD → WR for XOR-write, or RD → ACK otherwise.
  - WR → ACK.
- Reset mid-operation:
  - Pending fetch, pending CPU access and any clear are all abandoned.
  - No `ack` or `cpu_ack` is issued for them.
  - RAM keeps partial contents.

## Timing
- Reset values:
  - `data` = 0, `ack` = 0.
  - `cpu_rdata` = 0, `cpu_collision` = 0, `cpu_ack` = 0.
  - `busy` = 0.
- OLED fetch, uncontended (`read` at cycle T):
  - RAM reads issued at T+1..T+4.
  - `ack` at T+6.
  - Each cycle the port is taken by the CPU or by clear delays `ack` by 1.
- CPU op, uncontended (`cpu_req` at T):
  - Read or write: `cpu_ack` at T+3.
  - XOR-write: `cpu_ack` at T+4.
  - Clear in progress delays `cpu_ack` until `busy` falls, plus the base latency.
- Clear (`cls` at T): `busy` is high for T+1..T+256 and low at T+257.
- Simultaneous `cpu_req` and `read`: the CPU access completes first; the fetch starts after it.
- Simultaneous `cls` and `cpu_req`: the clear runs first. A CPU write latched at the same time lands after the clear and persists.

## Test plan
- Reset, then `cls`:
  - `busy` is high for exactly 256 cycles.
  - A subsequent `read` with `row_idx`=3, `column_idx`=77 returns `data`=0x00.
- Write 0x80 to address 0x00, then `read` with row 0, column 0 and with row 0, column 1:
  - Both return `data`=0x03.
  - Column 2 returns 0x00.
  - Uncontended `ack` arrives 6 cycles after `read`.
- Write 0xFF to addresses 0x18 (row 3) and 0xF8 (row 31):
  - Page 0, column 0 → 0xC0.
  - Page 7, column 0 → 0xC0.
  - Page 7, column 127 → 0x00.
- XOR-write 0x0F to address 0x42, which holds 0x3C:
  - `cpu_rdata`=0x3C, `cpu_collision`=1.
  - A read back returns 0x33.
  - XOR-write 0x40 to a byte holding 0x00 gives `cpu_collision`=0.
- Issue `read` and `cpu_req` (XOR-write) in the same cycle:
  - `cpu_ack` at +4.
  - `ack` at +8.
  - Fetched data reflects the post-XOR byte.
- Assert `rst_n` low in the middle of a fetch and of a clear:
  - All outputs return to their reset values immediately.
  - No stray `ack` or `cpu_ack` appears after release.
